wb_regfile_stage: RTL
=====================

WB_REGFILE_STAGE -- requirements
Module: wb_regfile_stage

Interface
REQ-001 Parameters SHALL be DATA_W, default 32, register and datapath width; REG_CNT, default 32, number of architectural registers (5-bit index).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 reg_write_w  input  1  register write enable from the MEM/WB pipeline register.
REQ-005 result_src_w  input  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 reserved.
REQ-006 funct3_w  input  3  load type for extension.
REQ-007 alu_result_w  input  32  ALU result; bits [1:0] also give the load byte offset.
REQ-008 read_data_w  input  32  raw data-memory word.
REQ-009 pc_plus_4_w  input  32  link value.
REQ-010 rd_w  input  5  destination register index.
REQ-011 rs1_d, rs2_d  input  5 each  decode-stage source indices.
REQ-012 rd1_d, rd2_d  output  32 each  decode-stage operand values.
REQ-013 result_w  output  32  final writeback value, also for forwarding.

Function
REQ-014 result_w SHALL be combinational: 00 -> alu_result_w; 01 -> extended load; 10 -> pc_plus_4_w; 11 -> 0.
REQ-015 Byte lanes SHALL be selected by alu_result_w[1:0] = 0/1/2/3 -> bits [7:0]/[15:8]/[23:16]/[31:24].
REQ-016 Half lanes SHALL be selected by alu_result_w[1] = 0/1 -> [15:0]/[31:16]; alu_result_w[0] is ignored.
REQ-017 Load extension by funct3_w SHALL be: 000 LB sign-extended byte; 001 LH sign-extended half; 010 LW full word; 100 LBU zero-extended byte; 101 LHU zero-extended half; 011/110/111 full word.
REQ-018 The register array SHALL be REG_CNT x DATA_W flops, written on the rising clk edge when rst_n=1, reg_write_w=1 and rd_w!=0, with value result_w.
REQ-019 Register x0 SHALL never be written and SHALL always read 0.
REQ-020 Reads SHALL be combinational: rd1_d = reg[rs1_d], rd2_d = reg[rs2_d].
REQ-021 Write-through bypass SHALL apply: if rst_n=1, reg_write_w=1, rd_w!=0 and rsX_d==rd_w, then rdX_d = result_w in the same cycle.
REQ-022 The bypass SHALL apply independently to both ports, so rs1_d==rs2_d==rd_w yields result_w on both.
REQ-023 rsX_d=0 SHALL return 0 even when rd_w=0 with reg_write_w=1.
REQ-024 Write latency SHALL be one edge; a read in the cycle after the write returns the stored value from the array.
REQ-025 A write with reg_write_w=0 SHALL leave all registers unchanged regardless of rd_w or result_src_w.

Reset
REQ-026 While rst_n=0 at a rising clk edge, all registers SHALL be cleared to 0 and no write SHALL occur.
REQ-027 While rst_n=0, the bypass SHALL be disabled and rd1_d/rd2_d SHALL reflect array contents, which are 0 from the first reset edge onward.
REQ-028 Reset asserted in the middle of a write stream SHALL discard the write in that cycle; the first write SHALL take effect on the first edge with rst_n=1.
REQ-029 result_w SHALL remain combinational and unaffected by rst_n.

Verification
REQ-030 Reset then read: hold rst_n=0 for 2 edges with reg_write_w=1, rd_w=5, alu result 0x1234 -> every rs returns 0; x5=0 after reset release.
REQ-031 ALU write/read: result_src=00, alu_result_w=0xDEADBEEF, rd_w=7, reg_write_w=1 -> in the same cycle rs1_d=7 gives 0xDEADBEEF via bypass; the next cycle with reg_write_w=0 still gives 0xDEADBEEF.
REQ-032 Loads with read_data_w=0x80FF7F01:
- LB, offset 3 -> 0xFFFFFF80.
- LBU, offset 3 -> 0x00000080.
- LH, offset 2 -> 0xFFFF80FF.
- LHU, offset 0 -> 0x00007F01.
- LW -> 0x80FF7F01.
- Each value lands in rd_w.
REQ-033 x0 protection: reg_write_w=1, rd_w=0, alu_result_w=0xFFFFFFFF -> rs1_d=rs2_d=0 in the same cycle and after the edge.
REQ-034 Link and reserved select: result_src=10, pc_plus_4_w=0x00000104, rd_w=1 -> x1=0x104; result_src=11, rd_w=2 -> x2=0; rs1_d=rs2_d=1 -> both ports 0x104.

Source files
------------

// File: rtl/wb_regfile_stage.sv
// wb_regfile_stage: writeback result mux with load extension and a write-through register file
module wb_regfile_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write_w,
  input  logic [1:0]        result_src_w,
  input  logic [2:0]        funct3_w,
  input  logic [DATA_W-1:0] alu_result_w,
  input  logic [DATA_W-1:0] read_data_w,
  input  logic [DATA_W-1:0] pc_plus_4_w,
  input  logic [4:0]        rd_w,
  input  logic [4:0]        rs1_d,
  input  logic [4:0]        rs2_d,
  output logic [DATA_W-1:0] rd1_d,
  output logic [DATA_W-1:0] rd2_d,
  output logic [DATA_W-1:0] result_w
);
  logic [DATA_W-1:0] regs [REG_CNT];
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [DATA_W-1:0] ld;
  logic              we;
  // result select with lane pick and sign/zero extension of loads; reset has no effect here
  always_comb begin
    ld_b = read_data_w[{alu_result_w[1:0], 3'b000} +: 8];
    ld_h = read_data_w[{alu_result_w[1], 4'b0000} +: 16];
    ld = funct3_w == 3'b000 ? {{(DATA_W-8){ld_b[7]}}, ld_b} :
         funct3_w == 3'b001 ? {{(DATA_W-16){ld_h[15]}}, ld_h} :
         funct3_w == 3'b100 ? {{(DATA_W-8){1'b0}}, ld_b} :
         funct3_w == 3'b101 ? {{(DATA_W-16){1'b0}}, ld_h} : read_data_w;
    result_w = result_src_w == 2'b00 ? alu_result_w :
               result_src_w == 2'b01 ? ld :
               result_src_w == 2'b10 ? pc_plus_4_w : '0;
  end
  // reads bypass the in-flight write so decode sees it in the same cycle; x0 is hardwired to zero
  always_comb begin
    we = rst_n && reg_write_w && rd_w != 5'd0;
    rd1_d = rs1_d == 5'd0 ? '0 : (we && rs1_d == rd_w) ? result_w : regs[rs1_d];
    rd2_d = rs2_d == 5'd0 ? '0 : (we && rs2_d == rd_w) ? result_w : regs[rs2_d];
  end
  // array clears on reset; otherwise one write per edge, never to x0
  always_ff @(posedge clk) begin
    if (!rst_n)
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    else if (we)
      regs[rd_w] <= result_w;
  end
endmodule
